// File: rtl/frame_corruptor.sv
// Frame-aware error injector: corrupts payload beats (random, periodic single-bit or burst)
// while leaving frame-start and CRC beats untouched. Define FRAME_CORRUPTOR_ERR_CNT_EN for o_err_cnt.
module frame_corruptor #(
   parameter int          DATA_W    = 8,
   parameter int          ROWS      = 4,
   parameter int          COLS      = 1041,
   parameter int          FAS_LEN   = 16,
   parameter int          CRC_LEN   = 1,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   input  logic              i_sof,
   input  logic              i_fas,
   input  logic [1:0]        i_mode,
   input  logic [15:0]       i_err_period,
   input  logic [7:0]        i_burst_len,
   input  logic              i_inject,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_fas,
   output logic              o_busy,
   output logic [15:0]       o_err_cnt
);

   localparam int TOTAL = ROWS * COLS;
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TOTAL - 1);
   localparam logic [IDX_W-1:0] FIRST_ELIG = IDX_W'(FAS_LEN);
   localparam logic [IDX_W-1:0] END_ELIG   = IDX_W'(TOTAL - CRC_LEN);
   // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic              locked, locked_nxt;
   logic [31:0]       lfsr, lfsr_nxt;
   logic [15:0]       pc;
   logic [7:0]        rem;
   logic [1:0]        prev_mode;
   logic              mode_chg, elig, pc_hit;
   logic [DATA_W-1:0] mask, flip, data_out;

   always_comb begin
      idx_nxt    = idx;
      locked_nxt = locked;
      if (i_valid) begin
         if (i_sof) begin
            idx_nxt    = '0;
            locked_nxt = 1'b1;
         end else if (idx == IDX_LAST) begin
            idx_nxt = '0;
         end else begin
            idx_nxt = idx + IDX_W'(1);
         end
      end
      elig     = i_valid && locked_nxt && (idx_nxt >= FIRST_ELIG) && (idx_nxt < END_ELIG);
      mask     = (lfsr[DATA_W-1:0] == '0) ? '1 : lfsr[DATA_W-1:0];
      flip     = DATA_W'(1) << lfsr[BIT_W-1:0];
      mode_chg = (i_mode != prev_mode);
      pc_hit   = (i_err_period != 16'd0) && (pc == i_err_period - 16'd1);
      lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
   end

   // A mode change suppresses the stateful modes for that beat, matching the abort of pc/burst.
   always_comb begin
      data_out = i_data;
      case (i_mode)
         2'd1: if (elig) data_out = i_data ^ mask;
         2'd2: if (!mode_chg && elig && pc_hit) data_out = i_data ^ flip;
         2'd3: if (!mode_chg && state == BURST && elig) data_out = i_data ^ mask;
         default: data_out = i_data;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         idx       <= '0;
         locked    <= 1'b0;
         lfsr      <= LFSR_SEED;
         pc        <= '0;
         rem       <= '0;
         prev_mode <= 2'd0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_fas     <= 1'b0;
      end else begin
         prev_mode <= i_mode;
         o_valid   <= i_valid;
         o_fas     <= i_fas;
         if (i_valid) begin
            idx    <= idx_nxt;
            locked <= locked_nxt;
            lfsr   <= lfsr_nxt;
            o_data <= data_out;
         end

         if (mode_chg) begin
            pc <= '0;
         end else if (i_mode == 2'd2) begin
            if (i_err_period == 16'd0) pc <= '0;
            else if (elig) pc <= pc_hit ? 16'd0 : pc + 16'd1;
         end

         if (mode_chg) begin
            state <= IDLE;
            rem   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (i_mode == 2'd3 && i_inject && i_burst_len != 8'd0) begin
                     state <= BURST;
                     rem   <= i_burst_len;
                  end
               end
               BURST: begin
                  if (elig) begin
                     rem <= rem - 8'd1;
                     if (rem == 8'd1) state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy = (state == BURST);

`ifdef FRAME_CORRUPTOR_ERR_CNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) err_cnt <= '0;
      else if (i_valid && data_out != i_data && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
   end

   assign o_err_cnt = err_cnt;
`else
   assign o_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_corruptor.sv
// Randomized bench for frame_corruptor against a beat-level reference model of the corruption rules.
module tb_frame_corruptor;
   localparam int W = 8, ROWS = 4, COLS = 25, FAS = 4, CRC = 2;
   localparam int T = ROWS * COLS;
   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic         clk = 1'b0, rst = 1'b1;
   logic [W-1:0] data = '0;
   logic         valid = 1'b0, sof = 1'b0, fas = 1'b0, inject = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic [15:0]  period = 16'd0;
   logic [7:0]   blen = 8'd0;
   logic [W-1:0] o_data;
   logic         o_valid, o_fas, o_busy;
   logic [15:0]  o_err_cnt;

   frame_corruptor #(.DATA_W(W), .ROWS(ROWS), .COLS(COLS), .FAS_LEN(FAS), .CRC_LEN(CRC),
                     .LFSR_SEED(SEED)) dut (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_sof(sof), .i_fas(fas),
      .i_mode(mode), .i_err_period(period), .i_burst_len(blen), .i_inject(inject),
      .o_data(o_data), .o_valid(o_valid), .o_fas(o_fas), .o_busy(o_busy), .o_err_cnt(o_err_cnt));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   logic [31:0]  poly, m_lfsr;
   int           m_idx, m_pc, m_rem, m_err;
   bit           m_locked, e_valid, e_fas;
   logic [1:0]   m_prev_mode;
   int           total = 0, bad = 0, pos = 0;

   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ poly;
      return r;
   endfunction

   task automatic model_reset();
      m_lfsr = SEED; m_idx = 0; m_pc = 0; m_rem = 0; m_err = 0; m_locked = 0;
      m_prev_mode = 2'd0; e_valid = 0; e_fas = 0;
      exp_q.delete();
      exp_q.push_back('0);
   endtask

   task automatic model_step();
      logic [W-1:0] d, m, last;
      bit chg, elig;
      if (rst) begin
         model_reset();
         return;
      end
      last = exp_q.pop_front();
      chg = (mode != m_prev_mode);
      m_prev_mode = mode;
      if (valid) begin
         if (sof) begin m_idx = 0; m_locked = 1; end
         else m_idx = (m_idx + 1) % T;
      end
      elig = valid && m_locked && m_idx >= FAS && m_idx < T - CRC;
      m = m_lfsr[W-1:0];
      if (m == 0) m = '1;
      d = data;
      if (chg) begin m_pc = 0; m_rem = 0; end
      if (mode == 2'd1 && elig) d = d ^ m;
      if (mode == 2'd2 && !chg) begin
         if (period == 0) m_pc = 0;
         else if (elig) begin
            if (m_pc == period - 1) begin
               d = d ^ (W'(1) << (m_lfsr % W));
               m_pc = 0;
            end else m_pc++;
         end
      end
      if (mode == 2'd3 && !chg) begin
         if (m_rem > 0) begin
            if (elig) begin d = d ^ m; m_rem--; end
         end else if (inject && blen != 0) m_rem = blen;
      end
      if (valid) begin
         m_lfsr = lfsr_adv(m_lfsr);
`ifdef FRAME_CORRUPTOR_ERR_CNT_EN
         if (d != data && m_err < 65535) m_err++;
`endif
         exp_q.push_back(d);
      end else exp_q.push_back(last);
      e_valid = valid;
      e_fas = fas;
   endtask

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_val("data", 64'(o_data), 64'(exp_q[0]));
      check_val("valid", 64'(o_valid), 64'(e_valid));
      check_val("fas", 64'(o_fas), 64'(e_fas));
      check_val("busy", 64'(o_busy), 64'(m_rem > 0));
      check_val("err_cnt", 64'(o_err_cnt), 64'(m_err));
   endtask

   // ---------------- drivers ----------------
   task automatic beat(input bit inj, input bit force_sof);
      if (force_sof) pos = 0;
      valid = 1; sof = (pos == 0); fas = (pos < FAS); data = W'($urandom); inject = inj;
      step();
      pos = (pos + 1) % T;
      inject = 0;
   endtask

   task automatic gap();
      valid = 0; sof = 1'($urandom); fas = 0; data = W'($urandom); inject = 1'($urandom);
      step();
      inject = 0;
   endtask

   task automatic run(input int n, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) gap();
         beat(0, 0);
      end
   endtask

   task automatic go_to(input int p);
      for (int i = 0; i < T && pos != p; i++) beat(0, 0);
   endtask

   initial begin
      int taps[4] = '{32, 22, 2, 1};
      poly = '0;
      foreach (taps[i]) poly[taps[i] - 1] = 1'b1;
      model_reset();

      // reset: outputs held at zero while i_rst is high, even with activity on the inputs
      rst = 1; valid = 1; data = 8'hA5; fas = 1; sof = 1; mode = 2'd3; inject = 1; blen = 8'd4;
      step(); step();
      check_val("rst_busy", 64'(o_busy), 64'd0);
      rst = 0; valid = 0; sof = 0; fas = 0; inject = 0; mode = 2'd0;
      step();

      // beats before the first sof are never eligible
      mode = 2'd1; pos = 5;
      run(10, 0);

      // mode 0 pass-through: two frames of incrementing data
      mode = 2'd0; go_to(0);
      for (int i = 0; i < 2 * T; i++) begin
         valid = 1; sof = (pos == 0); fas = (pos < FAS); data = W'(i);
         step();
         pos = (pos + 1) % T;
      end
      check_val("err_mode0", 64'(o_err_cnt), 64'd0);

      // mode 1 random mask, with gaps
      mode = 2'd1;
      run(2 * T, 20);

      // mode 2 periodic, then period 0
      mode = 2'd2; period = 16'd4;
      run(2 * T, 10);
      mode = 2'd0; beat(0, 0);
      mode = 2'd2; period = 16'd0;
      run(T, 10);

      // mode 3 bursts: mid-frame, retrigger ignored, wrap across the protected tail/head
      mode = 2'd3; blen = 8'd5;
      go_to(50); beat(1, 0); beat(1, 0);
      run(8, 0);
      go_to(T - 4); beat(1, 0);
      run(15, 0);
      blen = 8'd0; beat(1, 0); beat(0, 0);
      check_val("blen0_idle", 64'(o_busy), 64'd0);

      // reset mid-burst with rem=3, then a fresh run from the seed
      blen = 8'd5; go_to(30); beat(1, 0); beat(0, 0); beat(0, 0);
      check_val("busy_rem3", 64'(o_busy), 64'd1);
      rst = 1; valid = 1; inject = 1; sof = 0; data = W'($urandom);
      step();
      check_val("rst_mid_data", 64'(o_data), 64'd0);
      rst = 0; inject = 0; pos = 0; mode = 2'd1;
      run(T + 10, 0);

      // mixed random traffic: mode switches, spurious sof, random injects and gaps
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3) begin
            mode = 2'($urandom);
            period = 16'($urandom_range(6));
            blen = 8'($urandom_range(8));
         end
         if ($urandom_range(99) < 20) gap();
         beat($urandom_range(99) < 6, $urandom_range(199) == 0);
      end

`ifdef FRAME_CORRUPTOR_ERR_CNT_EN
      mode = 2'd1;
      run(70000, 0);
      check_val("err_sat", 64'(o_err_cnt), 64'hFFFF);
`else
      mode = 2'd1;
      run(T, 0);
      check_val("err_off", 64'(o_err_cnt), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
